// File: rtl/fridge_status_tx_if.sv
// Byte-wide valid/ready link carrying status frames from the controller to the display/host side.
interface fridge_status_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/fridge_status_tx.sv
// Status read-back transmitter: snapshots fridge/freezer state and streams it as a 7-byte
// framed, XOR-checksummed packet on a request or a periodic auto-report tick.
module fridge_status_tx #(
    parameter int unsigned PERIOD = 1000,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            fgt,
    input  logic [4:0]            frt,
    input  logic [4:0]            fgc,
    input  logic [4:0]            frc,
    input  logic                  fgp,
    input  logic                  frp,
    fridge_status_tx_if.master    tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [3:0]            seq
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic [3:0] seq_q, seq_d;
    logic       done_q, done_d;
    logic       load;
    logic       auto_tick;
    logic       trigger;

    logic [4:0] fgt_q, frt_q, fgc_q, frc_q;
    logic       fgp_q, frp_q;

    logic [7:0] frame_b [7];
    logic [7:0] xor_chain [7];

    // Free-running auto-report counter; keeps counting while a frame is in flight.
    generate
        if (PERIOD == 0) begin : g_no_auto
            assign auto_tick = 1'b0;
        end else begin : g_auto
            localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign auto_tick = (cnt_q == LAST);
        end
    endgenerate

    assign trigger = start | auto_tick;

    always_comb begin
        frame_b[0] = HDR;
        frame_b[1] = {3'b000, fgt_q};
        frame_b[2] = {3'b001, frt_q};
        frame_b[3] = {3'b010, fgc_q};
        frame_b[4] = {3'b011, frc_q};
        frame_b[5] = {seq_q, 2'b00, fgp_q, frp_q};
        frame_b[6] = xor_chain[6];
    end

    assign xor_chain[0] = 8'h00;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_csum
            assign xor_chain[gi+1] = xor_chain[gi] ^ frame_b[gi];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        seq_d     = seq_q;
        done_d    = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger || pending_q) begin
                    load      = 1'b1;
                    state_d   = SEND;
                    idx_d     = 3'd0;
                    pending_d = 1'b0;
                end
            end
            SEND: begin
                // Triggers during a frame (including the last-byte edge) collapse into one.
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (tx.tx_ready) begin
                    if (idx_q == 3'd6) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        seq_d   = seq_q + 4'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            seq_q     <= 4'd0;
            done_q    <= 1'b0;
            fgt_q     <= 5'd0;
            frt_q     <= 5'd0;
            fgc_q     <= 5'd0;
            frc_q     <= 5'd0;
            fgp_q     <= 1'b0;
            frp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            done_q    <= done_d;
            if (load) begin
                fgt_q <= fgt;
                frt_q <= frt;
                fgc_q <= fgc;
                frc_q <= frc;
                fgp_q <= fgp;
                frp_q <= frp;
            end
        end
    end

    assign tx.tx_valid = (state_q == SEND);
    assign tx.tx_data  = (state_q == SEND) ? frame_b[idx_q] : 8'h00;
    assign busy        = (state_q == SEND);
    assign frame_done  = done_q;
    assign seq         = seq_q;
endmodule
